// File: rtl/uart_rx.sv
// uart_rx: receive side of the 8N1 serial link.
// The rx line is double-flopped into the clk domain and each frame is sampled
// at mid-bit. Every completed frame is reported with a one-cycle done_rx pulse,
// together with the received word and its error flags.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit between
// the last data bit and the stop bit. Without the macro, parity_err is tied to 0.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 19200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_active,
    output logic                  done_rx,
    output logic                  frame_err,
    output logic                  parity_err
);

    localparam int CLK_DIVIDE = CLK_FREQ / BAUD_RATE;
    localparam int HALF       = CLK_DIVIDE / 2;
    localparam int CNT_W      = $clog2(CLK_DIVIDE) + 1;
    localparam int IDX_W      = $clog2(DATA_WIDTH) + 1;

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLK_DIVIDE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;
`endif

    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   rx_data_reg;
    logic                    rx_active_reg;
    logic                    done_rx_reg;
    logic                    frame_err_reg;
    logic                    rx_meta_reg;
    logic                    rx_s_reg;
    logic                    rx_p_reg;
    logic                    data_sample;

    // Sample strobe for a data bit: last count of a DATA bit period.
    assign data_sample = (state_reg == ST_DATA) && (cnt_reg == CNT_BIT_LAST);

    // Two-flop synchronizer plus the previous synchronized value for edge detection.
    // All three reset to idle-high so no false start edge appears after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_p_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
            rx_p_reg    <= rx_s_reg;
        end
    end

    // Data shift register: each bit is captured when the index points at it (LSB first).
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
        always_ff @(posedge clk) begin
            if (rst) begin
                shift_reg[gi] <= 1'b0;
            end else if (data_sample && (idx_reg == IDX_W'(gi))) begin
                shift_reg[gi] <= rx_s_reg;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bad_reg;
    logic parity_err_reg;
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    // Receive FSM: bit timing, sampling, and the registered frame outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            rx_data_reg   <= '0;
            rx_active_reg <= 1'b0;
            done_rx_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            done_rx_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    cnt_reg <= '0;
                    idx_reg <= '0;
                    // Only a falling edge starts a frame; a held-low line does not.
                    if (rx_p_reg && !rx_s_reg) begin
                        state_reg     <= ST_START;
                        rx_active_reg <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_reg == CNT_HALF_LAST) begin
                        cnt_reg <= '0;
                        if (!rx_s_reg) begin
                            state_reg <= ST_DATA;
                        end else begin
                            // Start bit gone high at its midpoint: treat as a glitch.
                            state_reg     <= ST_IDLE;
                            rx_active_reg <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_reg == CNT_BIT_LAST) begin
                        cnt_reg <= '0;
                        idx_reg <= idx_reg + 1'b1;
                        if (idx_reg == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_reg <= ST_PARITY;
`else
                            state_reg <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_reg == CNT_BIT_LAST) begin
                        cnt_reg <= '0;
                        // Even parity: data bits and parity bit must XOR to 0.
                        parity_bad_reg <= (^shift_reg) ^ rx_s_reg;
                        state_reg      <= ST_STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_reg == CNT_BIT_LAST) begin
                        cnt_reg       <= '0;
                        state_reg     <= ST_DONE;
                        rx_active_reg <= 1'b0;
                        // Outputs load here so they are valid during the DONE cycle.
                        done_rx_reg   <= 1'b1;
                        rx_data_reg   <= shift_reg;
                        frame_err_reg <= !rx_s_reg;
`ifdef UART_RX_PARITY_EN
                        parity_err_reg <= parity_bad_reg;
`endif
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    cnt_reg       <= '0;
                    idx_reg       <= '0;
                    rx_active_reg <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_active = rx_active_reg;
    assign done_rx   = done_rx_reg;
    assign frame_err = frame_err_reg;

endmodule
